tl_ul_fragmenter: RTL and testbench

Parametrised TileLink-UL fragmenter placed between a wide system-bus port and a narrow-transfer slave crossing, such as the control crossing of a peripheral island. Each accepted A request whose size exceeds the slave's maximum transfer is split into aligned single-beat fragments. The fragment index is carried in the low bits of the outgoing source. D responses are gathered into one response to the master, and denied status is merged when that option is compiled in. One master transaction is in flight at a time.

---
 rtl/tl_ul_fragmenter.sv | 243 ++++++++++++++++++++++++
 tb/tb_tl_ul_fragmenter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_fragmenter.sv
// TileLink-UL fragmenter: splits oversized A requests into aligned single-beat fragments and gathers their D responses.
// Define FRAG_DENIED_EN to add the out_d_denied/in_d_denied ports and the sticky denied merge.
module tl_ul_fragmenter #(
  parameter int  DATA_BYTES = 8,
  parameter int  ADDR_W     = 31,
  parameter int  SRC_W      = 3,
  parameter int  SIZE_W     = 3,
  parameter int  MAX_LGSIZE = 2,
  localparam int LG_DB      = $clog2(DATA_BYTES),
  localparam int FRAG_W     = (LG_DB > MAX_LGSIZE) ? (LG_DB - MAX_LGSIZE) : 1,
  localparam int OSRC_W     = SRC_W + FRAG_W,
  localparam int OSIZE_W    = ($clog2(MAX_LGSIZE + 1) > 1) ? $clog2(MAX_LGSIZE + 1) : 1,
  localparam int DATA_W     = 8 * DATA_BYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  in_a_ready,
  input  logic                  in_a_valid,
  input  logic [2:0]            in_a_opcode,
  input  logic [2:0]            in_a_param,
  input  logic [SIZE_W-1:0]     in_a_size,
  input  logic [SRC_W-1:0]      in_a_source,
  input  logic [ADDR_W-1:0]     in_a_address,
  input  logic [DATA_BYTES-1:0] in_a_mask,
  input  logic [DATA_W-1:0]     in_a_data,
  input  logic                  in_a_corrupt,
  input  logic                  in_d_ready,
  output logic                  in_d_valid,
  output logic [2:0]            in_d_opcode,
  output logic [SIZE_W-1:0]     in_d_size,
  output logic [SRC_W-1:0]      in_d_source,
  output logic [DATA_W-1:0]     in_d_data,
`ifdef FRAG_DENIED_EN
  output logic                  in_d_denied,
  input  logic                  out_d_denied,
`endif
  input  logic                  out_a_ready,
  output logic                  out_a_valid,
  output logic [2:0]            out_a_opcode,
  output logic [2:0]            out_a_param,
  output logic [OSIZE_W-1:0]    out_a_size,
  output logic [OSRC_W-1:0]     out_a_source,
  output logic [ADDR_W-1:0]     out_a_address,
  output logic [DATA_BYTES-1:0] out_a_mask,
  output logic [DATA_W-1:0]     out_a_data,
  output logic                  out_a_corrupt,
  output logic                  out_d_ready,
  input  logic                  out_d_valid,
  input  logic [2:0]            out_d_opcode,
  input  logic [OSIZE_W-1:0]    out_d_size,
  input  logic [OSRC_W-1:0]     out_d_source,
  input  logic [DATA_W-1:0]     out_d_data
);

  localparam int CNT_W = FRAG_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  function automatic logic [ADDR_W-1:0] frag_addr(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] k);
    return base + (ADDR_W'(k) << MAX_LGSIZE);
  endfunction

  // Byte lanes of one beat covered by a 2^lg byte transfer starting at addr.
  function automatic logic [DATA_BYTES-1:0] frag_lanes(input logic [ADDR_W-1:0] addr, input int lg);
    logic [DATA_BYTES-1:0] lanes;
    int off;
    off = int'(addr[LG_DB-1:0]);
    for (int b = 0; b < DATA_BYTES; b++) begin
      lanes[b] = (b >= off) && (b < off + (32'sd1 << lg));
    end
    return lanes;
  endfunction

  state_e                state_q, state_d;
  logic [2:0]            op_q, op_d, param_q, param_d;
  logic [SIZE_W-1:0]     size_q, size_d;
  logic [SRC_W-1:0]      src_q, src_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_BYTES-1:0] mask_q, mask_d;
  logic [DATA_W-1:0]     data_q, data_d, gather_q, gather_d;
  logic                  corrupt_q, corrupt_d;
  logic [CNT_W-1:0]      n_q, n_d, issue_q, issue_d, ack_q, ack_d;
`ifdef FRAG_DENIED_EN
  logic                  denied_q, denied_d;
`endif

  logic [SIZE_W-1:0]     lg_s;
  logic [ADDR_W-1:0]     a_addr_s;
  logic [CNT_W-1:0]      d_idx_s;
  logic [DATA_BYTES-1:0] d_lanes_s;
  logic                  d_hit_s;
  logic [CNT_W-1:0]      n_new_s;
  logic                  unused_s;

  assign lg_s      = (int'(size_q) > MAX_LGSIZE) ? SIZE_W'(MAX_LGSIZE) : size_q;
  assign a_addr_s  = frag_addr(addr_q, issue_q);
  assign d_idx_s   = CNT_W'(out_d_source[FRAG_W-1:0]);
  assign d_lanes_s = frag_lanes(frag_addr(addr_q, d_idx_s), int'(lg_s));
  // Indices at or beyond N, and anything outside BUSY, are dropped.
  assign d_hit_s   = out_d_valid && (state_q == BUSY) && (d_idx_s < n_q);
  assign n_new_s   = (int'(in_a_size) > MAX_LGSIZE) ?
                     CNT_W'(32'd1 << (int'(in_a_size) - MAX_LGSIZE)) : CNT_W'(1'b1);
  assign unused_s  = ^{out_d_opcode, out_d_size, out_d_source[OSRC_W-1:FRAG_W]};

  assign in_a_ready    = (state_q == IDLE);
  assign out_a_valid   = (state_q == BUSY) && (issue_q < n_q);
  assign out_a_opcode  = op_q;
  assign out_a_param   = param_q;
  assign out_a_size    = OSIZE_W'(lg_s);
  assign out_a_source  = {src_q, issue_q[FRAG_W-1:0]};
  assign out_a_address = a_addr_s;
  assign out_a_mask    = mask_q & frag_lanes(a_addr_s, int'(lg_s));
  assign out_a_data    = data_q;
  assign out_a_corrupt = corrupt_q;
  assign out_d_ready   = (state_q == BUSY);
  assign in_d_valid    = (state_q == RESP);
  assign in_d_opcode   = (op_q == 3'd4) ? 3'd1 : 3'd0;
  assign in_d_size     = size_q;
  assign in_d_source   = src_q;
  assign in_d_data     = gather_q;
`ifdef FRAG_DENIED_EN
  assign in_d_denied   = denied_q;
`endif

  // Next-state, request latch, counters and response gather.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    param_d   = param_q;
    size_d    = size_q;
    src_d     = src_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    data_d    = data_q;
    corrupt_d = corrupt_q;
    n_d       = n_q;
    issue_d   = issue_q;
    ack_d     = ack_q;
    gather_d  = gather_q;
`ifdef FRAG_DENIED_EN
    denied_d  = denied_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_a_valid) begin
          op_d      = in_a_opcode;
          param_d   = in_a_param;
          size_d    = in_a_size;
          src_d     = in_a_source;
          addr_d    = in_a_address;
          mask_d    = in_a_mask;
          data_d    = in_a_data;
          corrupt_d = in_a_corrupt;
          n_d       = n_new_s;
          issue_d   = {CNT_W{1'b0}};
          ack_d     = {CNT_W{1'b0}};
          gather_d  = {DATA_W{1'b0}};
`ifdef FRAG_DENIED_EN
          denied_d  = 1'b0;
`endif
          state_d   = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (out_a_valid && out_a_ready) begin
          issue_d = issue_q + CNT_W'(1'b1);
        end else begin
          issue_d = issue_q;
        end
        if (d_hit_s) begin
          for (int b = 0; b < DATA_BYTES; b++) begin
            if (d_lanes_s[b]) begin
              gather_d[8*b +: 8] = out_d_data[8*b +: 8];
            end else begin
              gather_d[8*b +: 8] = gather_q[8*b +: 8];
            end
          end
          ack_d = ack_q + CNT_W'(1'b1);
`ifdef FRAG_DENIED_EN
          denied_d = denied_q | out_d_denied;
`endif
          if (ack_q + CNT_W'(1'b1) == n_q) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
          end
        end else begin
          ack_d = ack_q;
        end
      end
      RESP: begin
        if (in_d_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= 3'd0;
      param_q   <= 3'd0;
      size_q    <= {SIZE_W{1'b0}};
      src_q     <= {SRC_W{1'b0}};
      addr_q    <= {ADDR_W{1'b0}};
      mask_q    <= {DATA_BYTES{1'b0}};
      data_q    <= {DATA_W{1'b0}};
      corrupt_q <= 1'b0;
      n_q       <= {CNT_W{1'b0}};
      issue_q   <= {CNT_W{1'b0}};
      ack_q     <= {CNT_W{1'b0}};
      gather_q  <= {DATA_W{1'b0}};
`ifdef FRAG_DENIED_EN
      denied_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      param_q   <= param_d;
      size_q    <= size_d;
      src_q     <= src_d;
      addr_q    <= addr_d;
      mask_q    <= mask_d;
      data_q    <= data_d;
      corrupt_q <= corrupt_d;
      n_q       <= n_d;
      issue_q   <= issue_d;
      ack_q     <= ack_d;
      gather_q  <= gather_d;
`ifdef FRAG_DENIED_EN
      denied_q  <= denied_d;
`endif
    end
  end

endmodule

// File: tb/tb_tl_ul_fragmenter.sv
// Scoreboard bench for tl_ul_fragmenter with default parameters; covers FRAG_DENIED_EN when that macro is defined.
module tb_tl_ul_fragmenter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_a_ready, in_a_valid;
  logic [2:0]  in_a_opcode, in_a_param;
  logic [2:0]  in_a_size, in_a_source;
  logic [30:0] in_a_address;
  logic [7:0]  in_a_mask;
  logic [63:0] in_a_data;
  logic        in_a_corrupt;
  logic        in_d_ready, in_d_valid;
  logic [2:0]  in_d_opcode, in_d_size, in_d_source;
  logic [63:0] in_d_data;
  logic        out_a_ready, out_a_valid;
  logic [2:0]  out_a_opcode, out_a_param;
  logic [1:0]  out_a_size;
  logic [3:0]  out_a_source;
  logic [30:0] out_a_address;
  logic [7:0]  out_a_mask;
  logic [63:0] out_a_data;
  logic        out_a_corrupt;
  logic        out_d_ready, out_d_valid;
  logic [2:0]  out_d_opcode;
  logic [1:0]  out_d_size;
  logic [3:0]  out_d_source;
  logic [63:0] out_d_data;
`ifdef FRAG_DENIED_EN
  logic        in_d_denied, out_d_denied;
`endif

  tl_ul_fragmenter dut (
    .clk(clk), .rst_n(rst_n),
    .in_a_ready(in_a_ready), .in_a_valid(in_a_valid), .in_a_opcode(in_a_opcode),
    .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
    .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
    .in_a_corrupt(in_a_corrupt),
    .in_d_ready(in_d_ready), .in_d_valid(in_d_valid), .in_d_opcode(in_d_opcode),
    .in_d_size(in_d_size), .in_d_source(in_d_source), .in_d_data(in_d_data),
`ifdef FRAG_DENIED_EN
    .in_d_denied(in_d_denied), .out_d_denied(out_d_denied),
`endif
    .out_a_ready(out_a_ready), .out_a_valid(out_a_valid), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_a_corrupt(out_a_corrupt),
    .out_d_ready(out_d_ready), .out_d_valid(out_d_valid), .out_d_opcode(out_d_opcode),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_data(out_d_data)
  );

  typedef struct packed {
    logic [30:0] addr;
    logic [1:0]  size;
    logic [3:0]  src;
    logic [7:0]  mask;
    logic [2:0]  op;
    logic [63:0] data;
  } exp_a_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [2:0]  src;
    logic [63:0] data;
    logic        chk;
    logic        den;
  } exp_d_t;

  exp_a_t      exp_a_q[$];
  exp_d_t      exp_d_q[$];
  string       pn_q[$];
  logic [63:0] pa_q[$];
  logic [63:0] pe_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  exp_a_t      ea;
  exp_d_t      ed;
  string       pn;
  logic [63:0] pa, pe;
  logic        bad;

  function automatic exp_a_t mk_a(input logic [30:0] addr, input logic [1:0] size, input logic [3:0] src,
                                  input logic [7:0] mask, input logic [2:0] op, input logic [63:0] data);
    exp_a_t e;
    e.addr = addr; e.size = size; e.src = src; e.mask = mask; e.op = op; e.data = data;
    return e;
  endfunction

  function automatic exp_d_t mk_d(input logic [2:0] op, input logic [2:0] size, input logic [2:0] src,
                                  input logic [63:0] data, input logic chk, input logic den);
    exp_d_t e;
    e.op = op; e.size = size; e.src = src; e.data = data; e.chk = chk; e.den = den;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input string nm, input logic [63:0] act, input logic [63:0] exp);
    pn_q.push_back(nm);
    pa_q.push_back(act);
    pe_q.push_back(exp);
  endtask

  task automatic send_a(input logic [2:0] op, input logic [2:0] size, input logic [2:0] src,
                        input logic [30:0] addr, input logic [63:0] data);
    int t;
    in_a_valid = 1'b1; in_a_opcode = op; in_a_size = size; in_a_source = src;
    in_a_address = addr; in_a_data = data; in_a_mask = 8'hFF;
    t = 0;
    while (!in_a_ready && t < 50) begin tick(); t++; end
    if (t >= 50) probe("in_a_timeout", 64'd0, 64'd1);
    tick();
    in_a_valid = 1'b0;
  endtask

  task automatic send_d(input logic [3:0] src, input logic [63:0] data, input logic den);
    int t;
    out_d_valid = 1'b1; out_d_source = src; out_d_data = data;
`ifdef FRAG_DENIED_EN
    out_d_denied = den;
`else
    out_d_opcode = {2'b00, den & 1'b0};
`endif
    t = 0;
    while (!out_d_ready && t < 50) begin tick(); t++; end
    if (t >= 50) probe("out_d_timeout", 64'd0, 64'd1);
    tick();
    out_d_valid = 1'b0;
  endtask

  task automatic wait_a_drained();
    int t;
    t = 0;
    while (exp_a_q.size() != 0 && t < 50) begin tick(); t++; end
    if (t >= 50) probe("out_a_timeout", 64'(exp_a_q.size()), 64'd0);
  endtask

  task automatic wait_d_drained();
    int t;
    t = 0;
    while (exp_d_q.size() != 0 && t < 50) begin tick(); t++; end
    if (t >= 50) probe("in_d_timeout", 64'(exp_d_q.size()), 64'd0);
  endtask

  // Monitor: compares every fired fragment and response against the queues, then drains point probes.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_a_valid && out_a_ready) begin
        n_cmp++;
        if (exp_a_q.size() == 0) begin
          n_bad++;
          $display("FAIL out_a_extra: got addr=%h src=%h, expected no fragment", out_a_address, out_a_source);
        end else begin
          ea = exp_a_q.pop_front();
          if (out_a_address !== ea.addr || out_a_size !== ea.size || out_a_source !== ea.src ||
              out_a_mask !== ea.mask || out_a_opcode !== ea.op || out_a_data !== ea.data) begin
            n_bad++;
            $display("FAIL out_a_frag: got addr=%h size=%0d src=%h mask=%h op=%0d data=%h, expected addr=%h size=%0d src=%h mask=%h op=%0d data=%h",
                     out_a_address, out_a_size, out_a_source, out_a_mask, out_a_opcode, out_a_data,
                     ea.addr, ea.size, ea.src, ea.mask, ea.op, ea.data);
          end
        end
      end
      if (rst_n && in_d_valid && in_d_ready) begin
        n_cmp++;
        if (exp_d_q.size() == 0) begin
          n_bad++;
          $display("FAIL in_d_extra: got src=%h data=%h, expected no response", in_d_source, in_d_data);
        end else begin
          ed = exp_d_q.pop_front();
          bad = (in_d_opcode !== ed.op) || (in_d_size !== ed.size) || (in_d_source !== ed.src) ||
                (ed.chk && (in_d_data !== ed.data));
`ifdef FRAG_DENIED_EN
          bad = bad || (in_d_denied !== ed.den);
`endif
          if (bad) begin
            n_bad++;
            $display("FAIL in_d_resp: got op=%0d size=%0d src=%0d data=%h, expected op=%0d size=%0d src=%0d data=%h (checked=%0d den=%0d)",
                     in_d_opcode, in_d_size, in_d_source, in_d_data, ed.op, ed.size, ed.src, ed.data, ed.chk, ed.den);
          end
        end
      end
      while (pn_q.size() > 0) begin
        pn = pn_q.pop_front();
        pa = pa_q.pop_front();
        pe = pe_q.pop_front();
        n_cmp++;
        if (pa !== pe) begin
          n_bad++;
          $display("FAIL %s: got %h, expected %h", pn, pa, pe);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_a_valid = 1'b0; in_a_opcode = 3'd0; in_a_param = 3'd0; in_a_size = 3'd0; in_a_source = 3'd0;
    in_a_address = 31'd0; in_a_mask = 8'h00; in_a_data = 64'd0; in_a_corrupt = 1'b0;
    in_d_ready = 1'b1; out_a_ready = 1'b1;
    out_d_valid = 1'b0; out_d_opcode = 3'd0; out_d_size = 2'd2; out_d_source = 4'd0; out_d_data = 64'd0;
`ifdef FRAG_DENIED_EN
    out_d_denied = 1'b0;
`endif
    #1;
    probe("rst_in_a_ready", 64'(in_a_ready), 64'd1);
    probe("rst_out_a_valid", 64'(out_a_valid), 64'd0);
    probe("rst_out_d_ready", 64'(out_d_ready), 64'd0);
    probe("rst_in_d_valid", 64'(in_d_valid), 64'd0);
    probe("rst_in_d_data", in_d_data, 64'd0);
    probe("rst_out_a_mask", 64'(out_a_mask), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Get size 3 at 0x100, two fragments answered in reverse order.
    exp_a_q.push_back(mk_a(31'h100, 2'd2, 4'd10, 8'h0F, 3'd4, 64'd0));
    exp_a_q.push_back(mk_a(31'h104, 2'd2, 4'd11, 8'hF0, 3'd4, 64'd0));
    exp_d_q.push_back(mk_d(3'd1, 3'd3, 3'd5, 64'hBBBBBBBB_AAAAAAAA, 1'b1, 1'b0));
    send_a(3'd4, 3'd3, 3'd5, 31'h100, 64'd0);
    wait_a_drained();
    send_d(4'd11, 64'hBBBBBBBB_DEADBEEF, 1'b0);
    send_d(4'd10, 64'hCAFEF00D_AAAAAAAA, 1'b0);
    wait_d_drained();

    // PutFull size 1 at 0x202 through a zero-latency slave.
    exp_a_q.push_back(mk_a(31'h202, 2'd1, 4'd4, 8'h0C, 3'd0, 64'h01234567_89ABCDEF));
    exp_d_q.push_back(mk_d(3'd0, 3'd1, 3'd2, 64'd0, 1'b0, 1'b0));
    send_a(3'd0, 3'd1, 3'd2, 31'h202, 64'h01234567_89ABCDEF);
    probe("lat_out_a_valid", 64'(out_a_valid), 64'd1);
    out_d_valid = 1'b1; out_d_source = 4'd4; out_d_data = 64'h0;
    tick();
    out_d_valid = 1'b0;
    probe("lat_in_d_valid", 64'(in_d_valid), 64'd1);
    wait_d_drained();

    // Get size 0 at 0x005 with an out-of-range response first.
    exp_a_q.push_back(mk_a(31'h005, 2'd0, 4'd0, 8'h20, 3'd4, 64'd0));
    exp_d_q.push_back(mk_d(3'd1, 3'd0, 3'd0, 64'h0000AB00_00000000, 1'b1, 1'b0));
    send_a(3'd4, 3'd0, 3'd0, 31'h005, 64'd0);
    wait_a_drained();
    send_d(4'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    probe("oor_in_d_valid", 64'(in_d_valid), 64'd0);
    probe("oor_out_d_ready", 64'(out_d_ready), 64'd1);
    send_d(4'd0, 64'h1111AB22_22222222, 1'b0);
    wait_d_drained();

    // out_a backpressure for 5 cycles.
    out_a_ready = 1'b0;
    exp_a_q.push_back(mk_a(31'h040, 2'd2, 4'd6, 8'h0F, 3'd4, 64'd0));
    exp_a_q.push_back(mk_a(31'h044, 2'd2, 4'd7, 8'hF0, 3'd4, 64'd0));
    exp_d_q.push_back(mk_d(3'd1, 3'd3, 3'd3, 64'h66666666_77777777, 1'b1, 1'b0));
    send_a(3'd4, 3'd3, 3'd3, 31'h040, 64'd0);
    for (int i = 0; i < 5; i++) begin
      probe("bp_out_a_valid", 64'(out_a_valid), 64'd1);
      probe("bp_out_a_address", 64'(out_a_address), 64'h40);
      probe("bp_out_a_source", 64'(out_a_source), 64'd6);
      tick();
    end
    out_a_ready = 1'b1;
    wait_a_drained();
    send_d(4'd6, 64'h55555555_77777777, 1'b0);
    send_d(4'd7, 64'h66666666_88888888, 1'b0);
    wait_d_drained();

    // in_d backpressure for 3 cycles in RESP.
    in_d_ready = 1'b0;
    exp_a_q.push_back(mk_a(31'h00C, 2'd2, 4'd2, 8'hF0, 3'd4, 64'd0));
    exp_d_q.push_back(mk_d(3'd1, 3'd2, 3'd1, 64'h11223344_00000000, 1'b1, 1'b0));
    send_a(3'd4, 3'd2, 3'd1, 31'h00C, 64'd0);
    wait_a_drained();
    send_d(4'd2, 64'h11223344_55667788, 1'b0);
    for (int i = 0; i < 3; i++) begin
      probe("hold_in_d_valid", 64'(in_d_valid), 64'd1);
      probe("hold_in_d_data", in_d_data, 64'h11223344_00000000);
      probe("hold_in_d_source", 64'(in_d_source), 64'd1);
      probe("hold_in_a_ready", 64'(in_a_ready), 64'd0);
      tick();
    end
    in_d_ready = 1'b1;
    tick();
    probe("post_resp_in_a_ready", 64'(in_a_ready), 64'd1);

    // Reset with one fragment outstanding, then a fresh Get.
    exp_a_q.push_back(mk_a(31'h300, 2'd2, 4'd14, 8'h0F, 3'd4, 64'd0));
    exp_a_q.push_back(mk_a(31'h304, 2'd2, 4'd15, 8'hF0, 3'd4, 64'd0));
    send_a(3'd4, 3'd3, 3'd7, 31'h300, 64'd0);
    wait_a_drained();
    send_d(4'd14, 64'h99999999_99999999, 1'b0);
    rst_n = 1'b0;
    #1;
    probe("mid_rst_in_a_ready", 64'(in_a_ready), 64'd1);
    probe("mid_rst_out_a_valid", 64'(out_a_valid), 64'd0);
    probe("mid_rst_out_d_ready", 64'(out_d_ready), 64'd0);
    probe("mid_rst_in_d_valid", 64'(in_d_valid), 64'd0);
    probe("mid_rst_in_d_data", in_d_data, 64'd0);
    probe("mid_rst_out_a_address", 64'(out_a_address), 64'd0);
    probe("mid_rst_out_a_source", 64'(out_a_source), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_a_q.push_back(mk_a(31'h008, 2'd2, 4'd12, 8'h0F, 3'd4, 64'd0));
    exp_a_q.push_back(mk_a(31'h00C, 2'd2, 4'd13, 8'hF0, 3'd4, 64'd0));
    exp_d_q.push_back(mk_d(3'd1, 3'd3, 3'd6, 64'h22222222_33333333, 1'b1, 1'b0));
    send_a(3'd4, 3'd3, 3'd6, 31'h008, 64'd0);
    wait_a_drained();
    send_d(4'd12, 64'h44444444_33333333, 1'b0);
    send_d(4'd13, 64'h22222222_11111111, 1'b0);
    wait_d_drained();

`ifdef FRAG_DENIED_EN
    // Denied on the second fragment, then a clean transaction.
    exp_a_q.push_back(mk_a(31'h100, 2'd2, 4'd10, 8'h0F, 3'd4, 64'd0));
    exp_a_q.push_back(mk_a(31'h104, 2'd2, 4'd11, 8'hF0, 3'd4, 64'd0));
    exp_d_q.push_back(mk_d(3'd1, 3'd3, 3'd5, 64'h0000000C_0000000D, 1'b1, 1'b1));
    send_a(3'd4, 3'd3, 3'd5, 31'h100, 64'd0);
    wait_a_drained();
    send_d(4'd10, 64'h0000000E_0000000D, 1'b0);
    send_d(4'd11, 64'h0000000C_0000000F, 1'b1);
    wait_d_drained();
    exp_a_q.push_back(mk_a(31'h202, 2'd1, 4'd4, 8'h0C, 3'd0, 64'h0));
    exp_d_q.push_back(mk_d(3'd0, 3'd1, 3'd2, 64'd0, 1'b0, 1'b0));
    send_a(3'd0, 3'd1, 3'd2, 31'h202, 64'h0);
    wait_a_drained();
    send_d(4'd4, 64'h0, 1'b0);
    wait_d_drained();
`endif

    probe("exp_a_left", 64'(exp_a_q.size()), 64'd0);
    probe("exp_d_left", 64'(exp_d_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
